// File: rtl/c2h_packet_framer.sv
// Frames ADC FIFO payload into fixed-length XDMA C2H packets with its own tlast.
// Define C2H_FRAMER_HEADER_EN to prepend the {MAGIC,pkt_count} / {timestamp,length} header.
module c2h_packet_framer #(
    parameter int          DATA_WIDTH = 64,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int          PKT_WORDS  = 2048,
    parameter logic [31:0] MAGIC      = 32'h4010_A5A5
) (
    input  logic                  user_clk,
    input  logic                  user_rstn,
    input  logic                  dma_ena,
    input  logic                  fifo_prog_full,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           pkt_count,
    output logic                  tlast_err,
    output logic                  busy
);

    localparam int            CW       = $clog2(PKT_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

    if (DATA_WIDTH != 64 || KEEP_WIDTH != DATA_WIDTH / 8 ||
        PKT_WORDS < 2 || PKT_WORDS > 65536) begin : g_bad_cfg
        $error("c2h_packet_framer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FILL = 3'd1,
        HDR0      = 3'd2,
        HDR1      = 3'd3,
        DATA      = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   word_cnt;
    logic            in_data;
    logic            last_word;
    logic            data_hs;

`ifdef C2H_FRAMER_HEADER_EN
    logic [31:0]           ts_cnt;
    logic [31:0]           ts_r;
    logic [DATA_WIDTH-1:0] hdr_data;
    logic                  hdr_valid;
`endif

    // Both sides are AXI4-Stream: a beat transfers on a rising edge where valid and
    // ready are both high; valid never waits on ready, and a raised valid holds its
    // data until it transfers. In DATA the source is passed straight through, so
    // s_axis_tready follows m_axis_tready combinationally.
    assign in_data       = (state == DATA);
    assign last_word     = (word_cnt == LAST_IDX);
    assign data_hs       = in_data && s_axis_tvalid && m_axis_tready;
    assign s_axis_tready = in_data && m_axis_tready;
    assign m_axis_tlast  = in_data && last_word;
    assign m_axis_tkeep  = '1;
    assign busy          = (state != IDLE);

`ifdef C2H_FRAMER_HEADER_EN
    assign m_axis_tvalid = in_data ? s_axis_tvalid : hdr_valid;
    assign m_axis_tdata  = in_data ? s_axis_tdata  : hdr_data;
`else
    assign m_axis_tvalid = in_data && s_axis_tvalid;
    assign m_axis_tdata  = in_data ? s_axis_tdata : '0;
`endif

    always_ff @(posedge user_clk or negedge user_rstn) begin
        if (!user_rstn) begin
            state     <= IDLE;
            word_cnt  <= '0;
            pkt_count <= '0;
            tlast_err <= 1'b0;
`ifdef C2H_FRAMER_HEADER_EN
            ts_cnt    <= '0;
            ts_r      <= '0;
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
`endif
        end else begin
`ifdef C2H_FRAMER_HEADER_EN
            ts_cnt <= ts_cnt + 32'd1;
`endif
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (!dma_ena) begin
                        tlast_err <= 1'b0;
                        pkt_count <= '0;
                    end else begin
                        state <= WAIT_FILL;
                    end
                end
                WAIT_FILL: begin
                    if (!dma_ena) begin
                        state <= IDLE;
                    end else if (fifo_prog_full) begin
`ifdef C2H_FRAMER_HEADER_EN
                        state     <= HDR0;
                        ts_r      <= ts_cnt;
                        hdr_data  <= {MAGIC, pkt_count};
                        hdr_valid <= 1'b1;
`else
                        state <= DATA;
`endif
                    end
                end
`ifdef C2H_FRAMER_HEADER_EN
                HDR0: begin
                    if (m_axis_tready) begin
                        state    <= HDR1;
                        hdr_data <= {ts_r, 32'(PKT_WORDS)};
                    end
                end
                HDR1: begin
                    if (m_axis_tready) begin
                        state     <= DATA;
                        hdr_data  <= '0;
                        hdr_valid <= 1'b0;
                    end
                end
`endif
                DATA: begin
                    if (data_hs) begin
                        // The producer's tlast is only compared, never obeyed.
                        if (s_axis_tlast != last_word) tlast_err <= 1'b1;
                        if (last_word) begin
                            word_cnt  <= '0;
                            pkt_count <= pkt_count + 32'd1;
                            state     <= dma_ena ? WAIT_FILL : IDLE;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c2h_packet_framer.sv
// Randomized bench for c2h_packet_framer: packet-level reference model and scoreboard.
// Expectations follow C2H_FRAMER_HEADER_EN the same way the design build does.
module tb_c2h_packet_framer;

    localparam int          PKT   = 16;
    localparam logic [31:0] MAGIC = 32'h4010_A5A5;
`ifdef C2H_FRAMER_HEADER_EN
    localparam int HW = 2;
`else
    localparam int HW = 0;
`endif

    logic        user_clk;
    logic        user_rstn;
    logic        dma_ena;
    logic        fifo_prog_full;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] pkt_count;
    logic        tlast_err;
    logic        busy;

    c2h_packet_framer #(
        .DATA_WIDTH(64),
        .KEEP_WIDTH(8),
        .PKT_WORDS (PKT),
        .MAGIC     (MAGIC)
    ) dut (
        .user_clk      (user_clk),
        .user_rstn     (user_rstn),
        .dma_ena       (dma_ena),
        .fifo_prog_full(fifo_prog_full),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .tlast_err     (tlast_err),
        .busy          (busy)
    );

    // ---------------- clock / reset ----------------
    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    logic [31:0] edge_cnt = '0;
    always @(posedge user_clk) if (user_rstn) edge_cnt <= edge_cnt + 32'd1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] src_q[$];           // {tlast, data} waiting in the modelled FIFO
    logic [63:0] exp_q[$];           // payload words expected downstream, in order
    logic [31:0] exp_pkt = '0;       // expected pkt_count
    logic        exp_err = 1'b0;     // expected sticky tlast_err
    logic [31:0] exp_ts  = '0;       // expected timestamp of the current header
    int          pos       = 0;      // beat position inside current output packet
    int          beats     = 0;
    int          pkts_done = 0;
    logic        rand_ready = 1'b0;
    logic        rand_src   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_pkt(input int tl_idx, input logic [63:0] base);
        for (int i = 0; i < PKT; i++) begin
            src_q.push_back({(i == tl_idx), base + 64'(i)});
            exp_q.push_back(base + 64'(i));
        end
    endtask

    // Single-cycle fill indication while the framer waits in WAIT_FILL.
    task automatic pulse_fill();
        fifo_prog_full = 1'b1;
        @(negedge user_clk);
        fifo_prog_full = 1'b0;
        #2;
        check_eq("busy_in_pkt", 64'(busy), 64'd1);
        if (!rand_src) check_eq("first_beat_latency", 64'(m_axis_tvalid), 64'd1);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n;
        n = 0;
        while (pkts_done < target && n < budget) begin
            @(negedge user_clk);
            n++;
        end
        check_eq("pkt_in_time", 64'(pkts_done >= target), 64'd1);
        @(negedge user_clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge user_clk);
        #2;
    endtask

    // ---------------- bus process: source driver, sink driver, monitor ----------------
    initial begin : bus
        logic        consumed;
        logic        stalled;
        logic        fresh;
        logic        pend_cnt;
        logic        pend_err;
        logic [63:0] stall_data;
        logic [63:0] exp_word;
        consumed = 1'b0; stalled = 1'b0; fresh = 1'b1;
        pend_cnt = 1'b0; pend_err = 1'b0; stall_data = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge user_clk);
            if (user_rstn) begin
                if (pend_cnt) check_eq("pkt_count", 64'(pkt_count), 64'(exp_pkt));
                if (pend_err) check_eq("tlast_err", 64'(tlast_err), 64'(exp_err));
                pend_cnt = 1'b0;
                pend_err = 1'b0;
                m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(s_axis_tvalid && !consumed)) begin
                    if (src_q.size() > 0 && (!rand_src || $urandom_range(0, 1) == 1)) begin
                        s_axis_tvalid = 1'b1;
                        s_axis_tdata  = src_q[0][63:0];
                        s_axis_tlast  = src_q[0][64];
                    end else begin
                        s_axis_tvalid = 1'b0;
                        s_axis_tdata  = 64'($urandom);
                        s_axis_tlast  = 1'b0;
                    end
                end
                consumed = 1'b0;
                #1;
                if (stalled) begin
                    check_eq("stall_valid", 64'(m_axis_tvalid), 64'd1);
                    check_eq("stall_data", m_axis_tdata, stall_data);
                end
                stalled    = m_axis_tvalid && !m_axis_tready;
                stall_data = m_axis_tdata;
`ifdef C2H_FRAMER_HEADER_EN
                if (m_axis_tvalid && pos == 0 && fresh) begin
                    exp_ts = edge_cnt - 32'd1;
                    fresh  = 1'b0;
                end
`endif
                if (m_axis_tvalid && m_axis_tready) begin
                    if (pos < HW) begin
                        exp_word = (pos == 0) ? {MAGIC, exp_pkt} : {exp_ts, 32'(PKT)};
                        check_eq("hdr_word", m_axis_tdata, exp_word);
                    end else if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check_eq("payload", m_axis_tdata, exp_word);
                        if (s_axis_tlast != (pos == HW + PKT - 1)) exp_err = 1'b1;
                        pend_err = 1'b1;
                    end
                    check_eq("m_tlast", 64'(m_axis_tlast), 64'(pos == HW + PKT - 1));
                    pos++;
                    beats++;
                    if (pos == HW + PKT) begin
                        pos = 0;
                        fresh = 1'b1;
                        exp_pkt = exp_pkt + 32'd1;
                        pkts_done++;
                        pend_cnt = 1'b1;
                    end
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    void'(src_q.pop_front());
                    consumed = 1'b1;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int b0;
        int guard;
        user_rstn = 1'b0; dma_ena = 1'b0; fifo_prog_full = 1'b0;
        idle_cycles(3);
        check_eq("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check_eq("rst_m_tdata",  m_axis_tdata,       64'd0);
        check_eq("rst_pkt_count", 64'(pkt_count),    64'd0);
        check_eq("rst_tlast_err", 64'(tlast_err),    64'd0);
        check_eq("rst_busy",     64'(busy),          64'd0);
        check_eq("tkeep",        64'(m_axis_tkeep),  64'hFF);
        @(negedge user_clk);
        user_rstn = 1'b1;

        // Reset-and-enable: payload 0..15 with aligned tlast.
        load_pkt(PKT - 1, 64'd0);
        idle_cycles(2);
        dma_ena = 1'b1;
        #2 check_eq("busy_before_ena", 64'(busy), 64'd0);
        idle_cycles(1);
        check_eq("busy_after_ena", 64'(busy), 64'd1);
        repeat (8) @(negedge user_clk);
        #2 check_eq("no_beats_before_fill", 64'(beats), 64'd0);
        @(negedge user_clk);
        pulse_fill();
        wait_pkts(1, 200);
        check_eq("t1_pkt_count", 64'(pkt_count), 64'd1);
        check_eq("t1_tlast_err", 64'(tlast_err), 64'd0);

        // Backpressure: random tready and source gaps over three packets.
        dma_ena = 1'b0;
        idle_cycles(3);
        check_eq("clr_pkt_count", 64'(pkt_count), 64'd0);
        exp_pkt = '0;
        dma_ena = 1'b1;
        idle_cycles(2);
        rand_ready = 1'b1;
        rand_src   = 1'b1;
        for (int p = 0; p < 3; p++) begin
            load_pkt(PKT - 1, {32'($urandom), 32'($urandom)});
            @(negedge user_clk);
            pulse_fill();
            wait_pkts(pkts_done + 1, 400);
        end
        check_eq("bp_pkt_count", 64'(pkt_count), 64'd3);
        rand_ready = 1'b0;
        rand_src   = 1'b0;

        // Misaligned producer tlast on payload word 7.
        load_pkt(7, {32'($urandom), 32'($urandom)});
        @(negedge user_clk);
        pulse_fill();
        wait_pkts(pkts_done + 1, 200);
        check_eq("mis_tlast_err", 64'(tlast_err), 64'd1);
        dma_ena = 1'b0;
        idle_cycles(3);
        check_eq("mis_err_cleared", 64'(tlast_err), 64'd0);
        check_eq("mis_idle", 64'(busy), 64'd0);
        exp_err = 1'b0;
        exp_pkt = '0;

        // Disable mid-packet: the packet must still complete, then stay idle.
        dma_ena = 1'b1;
        idle_cycles(2);
        load_pkt(PKT - 1, {32'($urandom), 32'($urandom)});
        @(negedge user_clk);
        pulse_fill();
        guard = 0;
        while (pos - HW < 4 && guard < 100) begin
            @(negedge user_clk);
            guard++;
        end
        dma_ena = 1'b0;
        wait_pkts(pkts_done + 1, 200);
        idle_cycles(2);
        check_eq("dis_idle", 64'(busy), 64'd0);
        b0 = beats;
        fifo_prog_full = 1'b1;
        idle_cycles(20);
        check_eq("dis_no_beats", 64'(beats), 64'(b0));
        check_eq("dis_still_idle", 64'(busy), 64'd0);
        fifo_prog_full = 1'b0;
        exp_pkt = '0;
        check_eq("dis_pkt_cleared", 64'(pkt_count), 64'd0);

        // Counter wrap, then hold-off with no fill indication.
        dma_ena = 1'b1;
        idle_cycles(2);
        force dut.pkt_count = 32'hFFFF_FFFF;
        @(negedge user_clk);
        release dut.pkt_count;
        exp_pkt = 32'hFFFF_FFFF;
        idle_cycles(1);
        check_eq("wrap_preload", 64'(pkt_count), 64'hFFFF_FFFF);
        load_pkt(PKT - 1, {32'($urandom), 32'($urandom)});
        @(negedge user_clk);
        pulse_fill();
        wait_pkts(pkts_done + 1, 200);
        check_eq("wrap_pkt_count", 64'(pkt_count), 64'd0);
        b0 = beats;
        idle_cycles(100);
        check_eq("holdoff_beats", 64'(beats), 64'(b0));
        check_eq("holdoff_waiting", 64'(busy), 64'd1);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check_eq("src_q_drained", 64'(src_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
